// File: rtl/alu_pkg.sv
// Shared definitions for the ALU stimulus/checker slice.
//   - alu_op_t : ALU opcode encodings driven on alu_op
//   - state_t  : checker FSM states (also exported on the debug port)
//   - LFSR_POLY / DEFAULT_SEED : default LFSR constants
//   - lfsr_step: one step of a right-shifting Galois LFSR
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // x^16 + x^14 + x^13 + x^11 + 1 in right-shift Galois form
  localparam logic [15:0] LFSR_POLY    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Shift right; when the bit falling out is 1, fold the taps back in.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s,
                                            input logic [15:0] poly);
    return s[0] ? ((s >> 1) ^ poly) : (s >> 1);
  endfunction

endpackage

// File: rtl/alu_stim_checker_if.sv
// Bus between the stimulus/checker (master) and the 4-bit ALU under test
// (slave).
//   alu_a, alu_b, alu_op          : master -> slave, registered operands/opcode
//   alu_result, alu_carry,
//   alu_zero, alu_overflow        : slave -> master, ALU registered outputs
//
// Timing contract (no valid/ready pair; the exchange is fixed-latency):
// the master holds a vector stable for two cycles. The slave registers its
// outputs on the first rising edge after the vector appears, and the master
// samples them on the second edge. There is no back-pressure.
interface alu_stim_checker_if;
  import alu_pkg::*;

  logic [3:0] alu_a;
  logic [3:0] alu_b;
  alu_op_t    alu_op;
  logic [3:0] alu_result;
  logic       alu_carry;
  logic       alu_zero;
  logic       alu_overflow;

  modport master (
    output alu_a, alu_b, alu_op,
    input  alu_result, alu_carry, alu_zero, alu_overflow
  );

  modport slave (
    input  alu_a, alu_b, alu_op,
    output alu_result, alu_carry, alu_zero, alu_overflow
  );

endinterface

// File: rtl/alu_golden_model.sv
// Combinational reference model of the 4-bit ALU.
//   a, b     : operands
//   op       : ADD / SUB / AND / OR
//   result   : 4-bit result
//   carry    : carry out (ADD) or borrow (SUB); 0 for logic ops
//   zero     : result == 0
//   overflow : signed overflow for ADD/SUB; 0 for logic ops
module alu_golden_model
  import alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  alu_op_t    op,
  output logic [3:0] result,
  output logic       carry,
  output logic       zero,
  output logic       overflow
);

  logic [4:0] sum;
  logic [4:0] diff;

  // 5-bit arithmetic so bit 4 is the carry (ADD) or borrow (SUB)
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result   = 4'd0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        result   = sum[3:0];
        carry    = sum[4];
        overflow = (a[3] == b[3]) && (a[3] != sum[3]);
      end
      OP_SUB: begin
        result   = diff[3:0];
        carry    = diff[4];
        overflow = (a[3] != b[3]) && (a[3] != diff[3]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      default: result = 4'd0;
    endcase
  end

  assign zero = (result == 4'd0);

endmodule

// File: rtl/alu_stim_checker.sv
// Pseudo-random stimulus generator and checker for a registered 4-bit ALU.
// Each run applies num_vectors LFSR-derived vectors, two cycles per vector.
// Each ALU response is compared against a golden model.
//   clk, rst_n      : clock; asynchronous active-low reset
//   start           : begin a run (accepted only in IDLE)
//   num_vectors     : vectors per run (0..255), captured at start
//   seed            : LFSR seed, captured at start (0 selects DEFAULT_SEED)
//   alu             : master side of the ALU bus
//   busy, done      : run in progress / one-cycle end-of-run pulse
//   mismatch_count  : saturating count of failing vectors
//   first_fail_idx  : index of the first failing vector
//   fail_flag       : sticky, at least one mismatch this run
//   state_dbg       : current FSM state
module alu_stim_checker
  import alu_pkg::*;
#(
  parameter logic [15:0] LFSR_POLY    = alu_pkg::LFSR_POLY,
  parameter logic [15:0] DEFAULT_SEED = alu_pkg::DEFAULT_SEED
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [7:0]          num_vectors,
  input  logic [15:0]         seed,
  alu_stim_checker_if.master  alu,
  output logic                busy,
  output logic                done,
  output logic [7:0]          mismatch_count,
  output logic [7:0]          first_fail_idx,
  output logic                fail_flag,
  output state_t              state_dbg
);

  state_t      state;
  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;
  logic [15:0] seed_eff;
  logic [15:0] vec_src;
  logic [7:0]  num_lat;
  logic [7:0]  idx;
  logic        is_last;
  logic [6:0]  exp_flags;  // {result, carry, zero, overflow}
  logic [6:0]  obs_flags;
  logic [3:0]  g_result;
  logic        g_carry;
  logic        g_zero;
  logic        g_overflow;

  assign seed_eff = (seed == 16'd0) ? DEFAULT_SEED : seed;
  assign lfsr_nxt = lfsr_step(lfsr, LFSR_POLY);
  assign is_last  = (idx == (num_lat - 8'd1));

  // The vector for APPLY is loaded on the edge that enters APPLY. This lets
  // the ALU capture it on the APPLY->WAIT edge, so its registered response
  // is ready on the WAIT exit edge. The source is the seed when leaving
  // IDLE and the stepped LFSR when leaving WAIT.
  assign vec_src = (state == ST_IDLE) ? seed_eff : lfsr_nxt;

  alu_golden_model u_golden (
    .a        (vec_src[3:0]),
    .b        (vec_src[7:4]),
    .op       (alu_op_t'(vec_src[9:8])),
    .result   (g_result),
    .carry    (g_carry),
    .zero     (g_zero),
    .overflow (g_overflow)
  );

  assign obs_flags = {alu.alu_result, alu.alu_carry, alu.alu_zero, alu.alu_overflow};
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      lfsr           <= DEFAULT_SEED;
      num_lat        <= 8'd0;
      idx            <= 8'd0;
      exp_flags      <= 7'd0;
      alu.alu_a      <= 4'd0;
      alu.alu_b      <= 4'd0;
      alu.alu_op     <= OP_ADD;
      busy           <= 1'b0;
      done           <= 1'b0;
      mismatch_count <= 8'd0;
      first_fail_idx <= 8'd0;
      fail_flag      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            num_lat        <= num_vectors;
            lfsr           <= seed_eff;
            idx            <= 8'd0;
            mismatch_count <= 8'd0;
            first_fail_idx <= 8'd0;
            fail_flag      <= 1'b0;
            busy           <= 1'b1;
            if (num_vectors == 8'd0) begin
              // Empty run: ALU outputs keep their previous values
              state <= ST_FIN;
            end else begin
              state      <= ST_APPLY;
              alu.alu_a  <= vec_src[3:0];
              alu.alu_b  <= vec_src[7:4];
              alu.alu_op <= alu_op_t'(vec_src[9:8]);
              exp_flags  <= {g_result, g_carry, g_zero, g_overflow};
            end
          end
        end

        ST_APPLY: state <= ST_WAIT;

        ST_WAIT: begin
          if (obs_flags != exp_flags) begin
            if (mismatch_count != 8'hFF) mismatch_count <= mismatch_count + 8'd1;
            if (!fail_flag) first_fail_idx <= idx;
            fail_flag <= 1'b1;
          end
          lfsr <= lfsr_nxt;
          idx  <= idx + 8'd1;
          if (is_last) begin
            state <= ST_FIN;
          end else begin
            state      <= ST_APPLY;
            alu.alu_a  <= vec_src[3:0];
            alu.alu_b  <= vec_src[7:4];
            alu.alu_op <= alu_op_t'(vec_src[9:8]);
            exp_flags  <= {g_result, g_carry, g_zero, g_overflow};
          end
        end

        ST_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_stim_checker.sv
// Directed testbench for alu_stim_checker. It contains a behavioural
// registered ALU with selectable faults, and a bench-side model of the
// vector sequence that predicts mismatch counts.
module tb_alu_stim_checker;
  import alu_pkg::*;

  localparam logic [15:0] TB_SEED_DEF = 16'hACE1;
  localparam logic [15:0] TB_POLY     = 16'hB400;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start;
  logic [7:0]  num_i;
  logic [15:0] seed_i;
  logic        busy, done, fail_flag;
  logic [7:0]  mismatch_count, first_fail_idx;
  state_t      state_dbg;

  int n_checks = 0;
  int n_fails  = 0;
  int fault    = 0;  // 0 clean, 1 result bit0 stuck-at-0, 2 zero inverted

  alu_stim_checker_if alu_if ();

  alu_stim_checker dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .num_vectors    (num_i),
    .seed           (seed_i),
    .alu            (alu_if.master),
    .busy           (busy),
    .done           (done),
    .mismatch_count (mismatch_count),
    .first_fail_idx (first_fail_idx),
    .fail_flag      (fail_flag),
    .state_dbg      (state_dbg)
  );

  // ---------------- reference ALU arithmetic ----------------
  // Returns {result, carry, zero, overflow}. Signed overflow is found by
  // checking the range of the signed sum or difference.
  function automatic logic [6:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] op);
    int ia, ib, sa, sb, r, sr;
    logic c, v;
    logic [3:0] res;
    ia = int'(a); ib = int'(b);
    sa = (ia > 7) ? ia - 16 : ia;
    sb = (ib > 7) ? ib - 16 : ib;
    c = 1'b0; v = 1'b0; r = 0;
    case (op)
      2'b00: begin r = ia + ib; c = (r > 15);  sr = sa + sb; v = (sr > 7) || (sr < -8); end
      2'b01: begin r = ia - ib; c = (ia < ib); sr = sa - sb; v = (sr > 7) || (sr < -8); end
      2'b10: r = ia & ib;
      default: r = ia | ib;
    endcase
    res = r[3:0];
    return {res, c, (res == 4'd0), v};
  endfunction

  function automatic logic [15:0] tb_lfsr(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? TB_POLY : 16'h0000);
  endfunction

  // Behavioural ALU under test: registered, with optional faults
  always @(posedge clk) begin
    logic [6:0] v;
    v = alu_ref(alu_if.alu_a, alu_if.alu_b, alu_if.alu_op);
    if (fault == 1) v[3] = 1'b0;
    if (fault == 2) v[1] = ~v[1];
    {alu_if.alu_result, alu_if.alu_carry, alu_if.alu_zero, alu_if.alu_overflow} <= v;
  end

  // Predicts the mismatch count and first failing index for a run
  task automatic model_run(input logic [15:0] s, input int n, input int flt,
                           output int cnt, output int first);
    logic [15:0] l;
    logic [6:0]  r;
    logic        bad;
    l = (s == 16'd0) ? TB_SEED_DEF : s;
    cnt = 0; first = 0;
    for (int i = 0; i < n; i++) begin
      r = alu_ref(l[3:0], l[7:4], l[9:8]);
      bad = (flt == 1) ? r[3] : (flt == 2);
      if (bad) begin
        if (cnt == 0) first = i;
        if (cnt < 255) cnt++;
      end
      l = tb_lfsr(l);
    end
  endtask

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Issues start with seed s and count n. Returns the number of cycles
  // from the accepting edge to the edge where done first reads 1. If poke
  // is nonzero, start is pulsed again that many cycles into the run.
  task automatic run(input logic [15:0] s, input logic [7:0] n, input int poke,
                     output int cycles);
    @(negedge clk);
    start = 1'b1; seed_i = s; num_i = n;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_on_accept", 32'(busy), 32'd1);
    cycles = 0;
    while (done !== 1'b1 && cycles < 1000) begin
      @(posedge clk); #1;
      cycles++;
      if (poke != 0 && cycles == poke) begin
        start = 1'b1; num_i = 8'd3; seed_i = 16'h1111;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (done !== 1'b1) check("done_timeout", 32'(done), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc, exp_cnt, exp_first;
    rst_n = 1'b0; start = 1'b0; num_i = 8'd0; seed_i = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_alu_a", 32'(alu_if.alu_a), 32'd0);
    check("rst_mcount", 32'(mismatch_count), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Seed 0 selects ACE1: first vector A=1, B=E, ADD
    run(16'h0000, 8'd1, 0, cyc);
    check("n1_latency", 32'(cyc), 32'd3);
    check("n1_alu_a", 32'(alu_if.alu_a), 32'h1);
    check("n1_alu_b", 32'(alu_if.alu_b), 32'hE);
    check("n1_alu_op", 32'(alu_if.alu_op), 32'h0);
    check("n1_mcount", 32'(mismatch_count), 32'd0);
    check("n1_fail", 32'(fail_flag), 32'd0);
    check("n1_busy_at_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("n1_done_pulse", 32'(done), 32'd0);

    // Empty run: single-cycle latency, ALU outputs untouched
    run(16'h1234, 8'd0, 0, cyc);
    check("n0_latency", 32'(cyc), 32'd1);
    check("n0_alu_a", 32'(alu_if.alu_a), 32'h1);
    check("n0_alu_b", 32'(alu_if.alu_b), 32'hE);
    check("n0_mcount", 32'(mismatch_count), 32'd0);

    // Long clean run
    run(16'h0001, 8'd100, 0, cyc);
    check("n100_latency", 32'(cyc), 32'd201);
    check("n100_mcount", 32'(mismatch_count), 32'd0);
    check("n100_fail", 32'(fail_flag), 32'd0);

    // start while busy must not restart the run
    run(16'h0005, 8'd10, 4, cyc);
    check("poke_latency", 32'(cyc), 32'd21);
    check("poke_mcount", 32'(mismatch_count), 32'd0);

    // Result bit0 stuck-at-0
    fault = 1;
    model_run(16'hBEEF, 50, 1, exp_cnt, exp_first);
    run(16'hBEEF, 8'd50, 0, cyc);
    check("stuck_latency", 32'(cyc), 32'd101);
    check("stuck_fail", 32'(fail_flag), 32'(exp_cnt != 0));
    check("stuck_mcount", 32'(mismatch_count), 32'(exp_cnt));
    check("stuck_first", 32'(first_fail_idx), 32'(exp_first));
    repeat (3) @(posedge clk);
    #1;
    check("stuck_hold", 32'(mismatch_count), 32'(exp_cnt));

    // Inverted zero flag: every vector fails
    fault = 2;
    run(16'h5A5A, 8'd255, 0, cyc);
    check("zinv_latency", 32'(cyc), 32'd511);
    check("zinv_mcount", 32'(mismatch_count), 32'd255);
    check("zinv_first", 32'(first_fail_idx), 32'd0);
    check("zinv_fail", 32'(fail_flag), 32'd1);

    // Mid-run reset around vector 10, then rerun with the same seed
    fault = 2;
    @(negedge clk);
    start = 1'b1; seed_i = 16'h0777; num_i = 8'd100;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy), 32'd1);
    #2; rst_n = 1'b0; #1;
    check("mid_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_a", 32'(alu_if.alu_a), 32'd0);
    check("mid_rst_b", 32'(alu_if.alu_b), 32'd0);
    check("mid_rst_op", 32'(alu_if.alu_op), 32'd0);
    check("mid_rst_mcount", 32'(mismatch_count), 32'd0);
    check("mid_rst_first", 32'(first_fail_idx), 32'd0);
    check("mid_rst_fail", 32'(fail_flag), 32'd0);
    fault = 0;
    @(negedge clk); rst_n = 1'b1;
    run(16'h0777, 8'd100, 0, cyc);
    check("rerun_latency", 32'(cyc), 32'd201);
    check("rerun_mcount", 32'(mismatch_count), 32'd0);
    check("rerun_fail", 32'(fail_flag), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/alu_stim_checker.md
ALU_STIM_CHECKER -- requirements
Module: alu_stim_checker

Interface
REQ-001 SHALL have parameter LFSR_POLY, default 16'hB400, Galois LFSR feedback taps (x^16+x^14+x^13+x^11+1).
REQ-002 SHALL have parameter DEFAULT_SEED, default 16'hACE1, substituted when seed input is zero.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin a run; sampled only in IDLE.
REQ-006 num_vectors  input  8  vectors per run, captured at start; 0 to 255.
REQ-007 seed  input  16  LFSR seed, captured at start.
REQ-008 alu_a, alu_b  output  4 each  operands to the ALU under test, registered.
REQ-009 alu_op  output  2  opcode: 00 ADD, 01 SUB, 10 AND, 11 OR; registered.
REQ-010 alu_result  input  4; alu_carry, alu_zero, alu_overflow  input  1 each  ALU registered outputs.
REQ-011 busy  output  1  high from start acceptance until done.
REQ-012 done  output  1  one-cycle pulse at end of run.
REQ-013 mismatch_count  output  8  saturating count of failed vectors.
REQ-014 first_fail_idx  output  8  index (0-based) of first failing vector.
REQ-015 fail_flag  output  1  sticky: at least one mismatch this run.

Function
REQ-016 FSM SHALL have states IDLE, APPLY, WAIT, FIN.
REQ-017 In IDLE with start=1: latch num_vectors, load LFSR with seed (DEFAULT_SEED if seed==0), clear mismatch_count, first_fail_idx, fail_flag, and vector index; go to APPLY, or to FIN if num_vectors==0.
REQ-018 APPLY SHALL register alu_a=lfsr[3:0], alu_b=lfsr[7:4], alu_op=lfsr[9:8], and the golden expected flags for that vector; next state WAIT.
REQ-019 WAIT: ALU has captured the vector on the APPLY->WAIT edge; on the WAIT exit edge compare {alu_result,alu_carry,alu_zero,alu_overflow} against the expected 7 bits.
REQ-020 On WAIT exit: step LFSR once, increment index; go to FIN if index==num_vectors-1, else APPLY. Each vector takes exactly 2 cycles.
REQ-021 On mismatch: mismatch_count+1, saturating at 255; set fail_flag; if fail_flag was 0, load first_fail_idx with the current index.
REQ-022 FIN: assert done for one cycle, deassert busy, return to IDLE; results hold until next start.
REQ-023 start outside IDLE SHALL be ignored; start in FIN is not accepted until IDLE.
REQ-024 Golden ADD: 5-bit A+B, result=sum[3:0], carry=sum[4], overflow=(A3==B3)&&(A3!=sum3).
REQ-025 Golden SUB: 5-bit A-B, result=diff[3:0], carry=diff[4] (borrow), overflow=(A3!=B3)&&(A3!=diff3).
REQ-026 Golden AND/OR: bitwise result, carry=0, overflow=0; zero=(result==0) for all ops.
REQ-027 Latency: done pulses 2N+1 cycles after the start-accepting edge (1 cycle for N=0).

Reset
REQ-028 rst_n low SHALL force, at any time including mid-run: state IDLE, alu_a/alu_b/alu_op=0, busy=0, done=0, mismatch_count=0, first_fail_idx=0, fail_flag=0, LFSR=DEFAULT_SEED, index=0.
REQ-029 After reset release, a run SHALL be accepted on the first cycle start=1.

Structure
REQ-030 Shared package alu_pkg SHALL hold op encodings, FSM state type, LFSR_POLY and DEFAULT_SEED constants.
REQ-031 Golden computation SHALL be a combinational sub-module alu_golden_model (A, B, op in; result, carry, zero, overflow out).

Verification
REQ-032 Clean ALU, seed 0, N=1 -> first vector A=1, B=E, op=ADD; expected result F, carry 0, zero 0, overflow 0; mismatch_count 0; done 3 cycles after start.
REQ-033 Clean ALU, seed 16'h0001, N=100 -> done after exactly 201 cycles, mismatch_count 0, fail_flag 0.
REQ-034 ALU with result bit0 stuck-at-0, N=50 -> fail_flag 1, mismatch_count and first_fail_idx equal the bench model's counts.
REQ-035 alu_zero forced inverted, N=255 -> mismatch_count 255 (saturated, no wrap), first_fail_idx 0.
REQ-036 N=0 -> done 1 cycle after start, alu_* unchanged, mismatch_count 0; start pulsed while busy -> ignored.
REQ-037 rst_n asserted at vector 10 of 100 -> all outputs zero immediately; a new run with the same seed then completes cleanly.
